// File: rtl/pe_drv_pkg.sv
// pe_drv_pkg: state encoding and cfg decode helpers
// shared by the PE stream driver files
package pe_drv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FILT,
        S_IFM,
        S_IPS,
        S_COLL,
        S_DONE
    } state_t;

    typedef logic [12:0] cfg_t;

    localparam int CFG_RS_LSB = 10;
    localparam int CFG_P_LSB  = 7;
    localparam int CFG_F_LSB  = 2;

    function automatic logic [2:0] rs_of(input cfg_t c);
        return {1'b0, c[CFG_RS_LSB +: 2]} + 3'd1;
    endfunction

    function automatic logic [2:0] p_of(input cfg_t c);
        return {1'b0, c[CFG_P_LSB +: 2]} + 3'd1;
    endfunction

    function automatic logic [4:0] f_of(input cfg_t c);
        return c[CFG_F_LSB +: 5];
    endfunction

    // words moved in one phase of the current column
    function automatic logic [4:0] phase_words(
        input state_t     s,
        input cfg_t       c,
        input logic [4:0] col
    );
        logic [4:0] rs;
        logic [4:0] p;
        rs = {2'b00, rs_of(c)};
        p  = {2'b00, p_of(c)};
        case (s)
            S_FILT:        phase_words = rs * p;
            S_IFM:         phase_words = (col == 5'd0) ? rs : 5'd1;
            S_IPS, S_COLL: phase_words = p;
            default:       phase_words = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/pe_stream_driver_if.sv
// pe_stream_driver_if: PE stream and GLB port bundle
// master = driver side, slave = PE / GLB side
interface pe_stream_driver_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CFG_W  = 13
);
    logic              pe_en;
    logic [CFG_W-1:0]  pe_config;
    logic              glb_rd_en;
    logic [ADDR_W-1:0] glb_rd_addr;
    logic [DATA_W-1:0] glb_rd_data;
    logic              glb_wr_en;
    logic [ADDR_W-1:0] glb_wr_addr;
    logic [DATA_W-1:0] glb_wr_data;
    logic [DATA_W-1:0] filter;
    logic              filter_valid;
    logic              filter_ready;
    logic [DATA_W-1:0] ifmap;
    logic              ifmap_valid;
    logic              ifmap_ready;
    logic [DATA_W-1:0] ipsum;
    logic              ipsum_valid;
    logic              ipsum_ready;
    logic [DATA_W-1:0] opsum;
    logic              opsum_valid;
    logic              opsum_ready;

    modport master (
        output pe_en, pe_config,
        output glb_rd_en, glb_rd_addr,
        input  glb_rd_data,
        output glb_wr_en, glb_wr_addr, glb_wr_data,
        output filter, filter_valid, input filter_ready,
        output ifmap, ifmap_valid, input ifmap_ready,
        output ipsum, ipsum_valid, input ipsum_ready,
        input  opsum, opsum_valid, output opsum_ready
    );

    modport slave (
        input  pe_en, pe_config,
        input  glb_rd_en, glb_rd_addr,
        output glb_rd_data,
        input  glb_wr_en, glb_wr_addr, glb_wr_data,
        input  filter, filter_valid, output filter_ready,
        input  ifmap, ifmap_valid, output ifmap_ready,
        input  ipsum, ipsum_valid, output ipsum_ready,
        output opsum, opsum_valid, input opsum_ready
    );
endinterface

// File: rtl/pe_drv_fifo2.sv
// pe_drv_fifo2: 2-entry valid/ready FIFO with flush
// count is exported so the producer can reserve space
module pe_drv_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rp];
    assign count     = cnt;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // storage and pointers; flush drops all entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else if (flush) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/pe_stream_driver.sv
// pe_stream_driver: GLB-to-PE stream initiator and opsum drain
// Optional stall counter enabled by PE_DRV_STALL_CNT_EN
module pe_stream_driver
    import pe_drv_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CFG_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CFG_W-1:0]  cfg,
    input  logic [ADDR_W-1:0] filter_base,
    input  logic [ADDR_W-1:0] ifmap_base,
    input  logic [ADDR_W-1:0] ipsum_base,
    input  logic [ADDR_W-1:0] opsum_base,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stall_cnt,
    pe_stream_driver_if.master bus
);
    state_t            state;
    state_t            state_nxt;
    cfg_t              cfg_q;
    logic [ADDR_W-1:0] fb_q, ib_q, pb_q, ob_q;
    logic [4:0]        col_q, rd_cnt, tx_cnt, n_words;
    logic              infl_q;
    logic              f_in_ready, f_valid, f_ready;
    logic [DATA_W-1:0] f_data;
    logic [1:0]        f_count;
    logic              rd_phase, rd_en, room, pop;
    logic              last_rd, wr_en, last_wr, last_col;
    logic [ADDR_W-1:0] rd_addr, k_a, col_a, rs_a, p_a;

    assign n_words  = phase_words(state, cfg_q, col_q);
    assign k_a      = ADDR_W'(rd_cnt);
    assign col_a    = ADDR_W'(col_q);
    assign rs_a     = ADDR_W'(rs_of(cfg_q));
    assign p_a      = ADDR_W'(p_of(cfg_q));
    assign rd_phase = state inside {S_FILT, S_IFM, S_IPS};
    assign last_col = col_q == f_of(cfg_q);

    // active stream select: ready source and GLB read address
    always_comb begin
        f_ready = 1'b0;
        rd_addr = '0;
        unique case (1'b1)
            state == S_FILT: begin
                f_ready = bus.filter_ready;
                rd_addr = fb_q + k_a;
            end
            state == S_IFM: begin
                f_ready = bus.ifmap_ready;
                rd_addr = (col_q == 5'd0) ? ib_q + k_a
                        : ib_q + rs_a + col_a - ADDR_W'(1);
            end
            state == S_IPS: begin
                f_ready = bus.ipsum_ready;
                rd_addr = pb_q + col_a * p_a + k_a;
            end
            default: ;
        endcase
    end

    // a read may issue only if the FIFO can still hold it
    // together with the one already in flight
    assign pop     = f_valid & f_ready;
    assign room    = f_in_ready &
                     (({1'b0, f_count} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
    assign rd_en   = rd_phase & (rd_cnt < n_words) & room;
    assign last_rd = pop & (tx_cnt == n_words - 5'd1);
    assign wr_en   = (state == S_COLL) & bus.opsum_valid;
    assign last_wr = wr_en & (tx_cnt == n_words - 5'd1);

    pe_drv_fifo2 #(.W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (state == S_IDLE),
        .in_valid  (infl_q),
        .in_data   (bus.glb_rd_data),
        .in_ready  (f_in_ready),
        .out_valid (f_valid),
        .out_data  (f_data),
        .out_ready (f_ready),
        .count     (f_count)
    );

    assign busy            = (state != S_IDLE) && (state != S_DONE);
    assign bus.pe_en       = state == S_ISSUE;
    assign bus.pe_config   = cfg_q;
    assign bus.glb_rd_en   = rd_en;
    assign bus.glb_rd_addr = rd_en ? rd_addr : '0;
    assign bus.glb_wr_en   = wr_en;
    assign bus.glb_wr_addr = wr_en ? ob_q + col_a * p_a + ADDR_W'(tx_cnt) : '0;
    assign bus.glb_wr_data = wr_en ? bus.opsum : '0;
    assign bus.opsum_ready = state == S_COLL;
    assign bus.filter_valid = f_valid & (state == S_FILT);
    assign bus.ifmap_valid  = f_valid & (state == S_IFM);
    assign bus.ipsum_valid  = f_valid & (state == S_IPS);
    assign bus.filter = bus.filter_valid ? f_data : '0;
    assign bus.ifmap  = bus.ifmap_valid ? f_data : '0;
    assign bus.ipsum  = bus.ipsum_valid ? f_data : '0;

    // next-state: phases advance on their last handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_FILT;
            S_FILT:  if (last_rd) state_nxt = S_IFM;
            S_IFM:   if (last_rd) state_nxt = S_IPS;
            S_IPS:   if (last_rd) state_nxt = S_COLL;
            S_COLL:  if (last_wr) state_nxt = last_col ? S_DONE : S_IFM;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // job registers, per-phase counters, column index, done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q  <= '0;
            fb_q   <= '0;
            ib_q   <= '0;
            pb_q   <= '0;
            ob_q   <= '0;
            col_q  <= '0;
            rd_cnt <= '0;
            tx_cnt <= '0;
            infl_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            infl_q <= rd_en;
            done   <= last_wr & last_col;
            if (state == S_IDLE && start) begin
                cfg_q <= cfg;
                fb_q  <= filter_base;
                ib_q  <= ifmap_base;
                pb_q  <= ipsum_base;
                ob_q  <= opsum_base;
                col_q <= '0;
            end
            if (state_nxt != state) begin
                rd_cnt <= '0;
                tx_cnt <= '0;
                if (state == S_COLL && state_nxt == S_IFM)
                    col_q <= col_q + 5'd1;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + 5'd1;
                if (pop | wr_en) tx_cnt <= tx_cnt + 5'd1;
            end
        end
    end

`ifdef PE_DRV_STALL_CNT_EN
    logic stall;

    assign stall = (bus.filter_valid & ~bus.filter_ready)
                 | (bus.ifmap_valid & ~bus.ifmap_ready)
                 | (bus.ipsum_valid & ~bus.ipsum_ready);

    // saturating stall counter, cleared when a job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == S_IDLE && start)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_stream_driver.sv
// tb_pe_stream_driver: directed checks of pe_stream_driver
// GLB and PE are modelled here; expected address ranges are hand-listed
`timescale 1ns/1ps
module tb_pe_stream_driver;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 13;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg   = '0;
    logic [AW-1:0] fb    = '0;
    logic [AW-1:0] ib    = '0;
    logic [AW-1:0] pb    = '0;
    logic [AW-1:0] ob    = '0;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cnt;

    int checks = 0;
    int errors = 0;
    int rmode = 0;
    int rcyc = 0;
    int op_seq = 0;
    int cyc = 0;
    int pe_en_cnt = 0;
    int done_cnt = 0;
    int stall_m = 0;
    int pe_en_cyc = -1;
    int fv_cyc = -1;
    int f_first = -1;
    int f_last = -1;
    logic        pend = 1'b0;
    logic [31:0] pend_d = '0;
    logic [3:0]  pat = 4'b1001;
    logic [31:0] fq[$];
    logic [31:0] iq[$];
    logic [31:0] pq[$];
    logic [31:0] wdq[$];
    logic [15:0] waq[$];

    pe_stream_driver_if #(.ADDR_W(AW), .DATA_W(DW), .CFG_W(CW)) bus ();

    pe_stream_driver #(.ADDR_W(AW), .DATA_W(DW), .CFG_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg         (cfg),
        .filter_base (fb),
        .ifmap_base  (ib),
        .ipsum_base  (pb),
        .opsum_base  (ob),
        .busy        (busy),
        .done        (done),
        .stall_cnt   (stall_cnt),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gdata(input logic [15:0] a);
        return {16'hDA7A, a};
    endfunction

    assign bus.opsum       = 32'h0B5E_0000 + op_seq;
    assign bus.opsum_valid = 1'b1;

    // GLB: one-cycle read latency
    always @(posedge clk)
        if (bus.glb_rd_en) bus.glb_rd_data <= gdata(bus.glb_rd_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // PE ready generation
    initial begin
        bus.filter_ready = 1'b1;
        bus.ifmap_ready  = 1'b1;
        bus.ipsum_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) begin
                bus.filter_ready = 1'b1;
            end else begin
                bus.filter_ready = (rcyc < 4) ? pat[rcyc]
                                 : 1'($urandom_range(0, 1));
                rcyc++;
            end
        end
    end

    // monitor: handshakes, pulses, hold rule, stalls
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.pe_en) begin
                    pe_en_cnt++;
                    pe_en_cyc = cyc;
                end
                if (done) done_cnt++;
                if (bus.filter_valid && fv_cyc < 0) fv_cyc = cyc;
                if (pend) begin
                    check("f_hold_valid", 32'(bus.filter_valid), 32'd1);
                    check("f_hold_data", bus.filter, pend_d);
                end
                pend   = bus.filter_valid & ~bus.filter_ready;
                pend_d = bus.filter;
                if ((bus.filter_valid & ~bus.filter_ready) |
                    (bus.ifmap_valid & ~bus.ifmap_ready) |
                    (bus.ipsum_valid & ~bus.ipsum_ready))
                    stall_m++;
                if (bus.filter_valid & bus.filter_ready) begin
                    fq.push_back(bus.filter);
                    if (f_first < 0) f_first = cyc;
                    f_last = cyc;
                end
                if (bus.ifmap_valid & bus.ifmap_ready) iq.push_back(bus.ifmap);
                if (bus.ipsum_valid & bus.ipsum_ready) pq.push_back(bus.ipsum);
                if (bus.opsum_ready & bus.opsum_valid) begin
                    check("wr_en", 32'(bus.glb_wr_en), 32'd1);
                    waq.push_back(bus.glb_wr_addr);
                    wdq.push_back(bus.glb_wr_data);
                    op_seq++;
                end
            end
        end
    end

    task automatic cmp_q(input string tag, input logic [31:0] got[$],
                         input logic [15:0] a0, input int n);
        check({tag, "_n"}, got.size(), n);
        for (int k = 0; k < n; k++)
            check(tag, (k < got.size()) ? got[k] : 32'bx, gdata(16'(a0 + k)));
    endtask

    task automatic pulse_start(input logic [12:0] c, input logic [15:0] o);
        @(posedge clk);
        #1;
        fq.delete(); iq.delete(); pq.delete(); waq.delete(); wdq.delete();
        pe_en_cnt = 0; done_cnt = 0; stall_m = 0; op_seq = 0; rcyc = 0;
        fv_cyc = -1; f_first = -1; f_last = -1; pe_en_cyc = -1;
        cfg = c; fb = 16'h0010; ib = 16'h0040; pb = 16'h0080; ob = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(
        input string tag, input logic [12:0] c, input logic [15:0] o,
        input int t4, input int span,
        input int fn, input int inn, input int pn, input int wn
    );
        int n;
        bit armed;
        n = 0;
        armed = (t4 != 0);
        pulse_start(c, o);
        while (done_cnt == 0 && n < 500) begin
            @(negedge clk);
            n++;
            if (armed && bus.ipsum_valid) begin
                start = 1'b1;
                cfg = 13'h1FFF; fb = 16'h9999; ob = 16'h7777;
                armed = 1'b0;
                @(negedge clk);
                start = 1'b0;
                n++;
            end
        end
        check({tag, "_timeout"}, 32'(n < 500), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_pe_en_cnt"}, pe_en_cnt, 1);
        check({tag, "_pe_config"}, 32'(bus.pe_config), 32'(c));
        check({tag, "_latency"}, 32'((fv_cyc - pe_en_cyc) >= 3), 32'd1);
        if (span != 0) check({tag, "_f_span"}, f_last - f_first, fn - 1);
        cmp_q({tag, "_filter"}, fq, 16'h0010, fn);
        cmp_q({tag, "_ifmap"}, iq, 16'h0040, inn);
        cmp_q({tag, "_ipsum"}, pq, 16'h0080, pn);
        check({tag, "_wr_n"}, waq.size(), wn);
        for (int k = 0; k < wn; k++) begin
            check({tag, "_wr_addr"}, (k < waq.size()) ? {16'h0, waq[k]} : 32'bx,
                  {16'h0, 16'(o + k)});
            check({tag, "_wr_data"}, (k < wdq.size()) ? wdq[k] : 32'bx,
                  32'h0B5E_0000 + k);
        end
`ifdef PE_DRV_STALL_CNT_EN
        check({tag, "_stall"}, stall_cnt, stall_m);
`else
        check({tag, "_stall"}, stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pe_en", 32'(bus.pe_en), 0);
        check("rst_fvalid", 32'(bus.filter_valid), 0);
        check("rst_ivalid", 32'(bus.ifmap_valid), 0);
        check("rst_pvalid", 32'(bus.ipsum_valid), 0);
        check("rst_rd_en", 32'(bus.glb_rd_en), 0);
        check("rst_wr_en", 32'(bus.glb_wr_en), 0);
        check("rst_oready", 32'(bus.opsum_ready), 0);
        check("rst_pe_config", 32'(bus.pe_config), 0);
        check("rst_rd_addr", 32'(bus.glb_rd_addr), 0);
        check("rst_filter", bus.filter, 0);
        check("rst_stall", stall_cnt, 0);
        #2 rst = 1'b0;

        // T1: rs=3 p=2 F=0
        run_job("t1", 13'h0880, 16'h00C0, 0, 1, 6, 3, 2, 2);
        // T2: rs=3 p=1 F=2
        run_job("t2", 13'h0808, 16'h00C0, 0, 1, 3, 5, 3, 3);
        // T3: filter backpressure
        rmode = 1;
        run_job("t3", 13'h0880, 16'h00C0, 0, 0, 6, 3, 2, 2);
        rmode = 0;
        // T4: extra start during IPS
        run_job("t4", 13'h0880, 16'h00C0, 1, 1, 6, 3, 2, 2);

        // T5: async reset mid-FILT
        pulse_start(13'h0880, 16'h00C0);
        n = 0;
        while (!bus.filter_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_filt", 32'(n < 50), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_fvalid", 32'(bus.filter_valid), 0);
        check("t5_filter", bus.filter, 0);
        check("t5_rd_en", 32'(bus.glb_rd_en), 0);
        check("t5_rd_addr", 32'(bus.glb_rd_addr), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_pe_config", 32'(bus.pe_config), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_job("t5", 13'h0880, 16'h00C0, 0, 1, 6, 3, 2, 2);

        // T6: opsum address wrap, rs=1 p=2 F=0
        run_job("t6", 13'h0080, 16'hFFFF, 0, 1, 2, 1, 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
